updown_step_ctrl: RTL and testbench

//  Sequencer for the synchronous up/down counter. Accepts "move N steps up/down" commands over a

---
 rtl/updown_step_ctrl.sv | 130 +++++++++++++
 tb/tb_updown_step_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/updown_step_ctrl.sv
// Step sequencer for an up/down counter: accepts "move N steps" commands
// over valid/ready, drives direction and count-enable for N cycles, and
// keeps a mirror of the counter value. Ends with a one-cycle done pulse,
// qualified by aborted when the command was cut short.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a command; outputs hold the last command's results
// SETUP | one quiet cycle so the latched direction settles before stepping
// RUN   | stepping; one step per cycle unless abort is high
// DONE  | one-cycle completion pulse, not ready
module updown_step_ctrl #(
    parameter int WIDTH  = 2,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              abort,
    output logic              m,
    output logic              cnt_en,
    output logic [WIDTH-1:0]  q,
    output logic [STEP_W-1:0] steps_left,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_ZERO = '0;

    state_t            state_q, state_d;
    logic              m_q, m_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              aborted_q, aborted_d;

    logic              accept;
    logic              step;

    assign accept = (state_q == S_IDLE) && cmd_valid;
    assign step   = (state_q == S_RUN) && !abort;

    // State and datapath registers; reset wins over everything, no done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            m_q       <= 1'b0;
            cnt_q     <= '0;
            steps_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            steps_q   <= steps_d;
            aborted_q <= aborted_d;
        end
    end

    // Next state and next datapath values.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        steps_d   = steps_q;
        aborted_d = aborted_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    m_d       = cmd_dir;
                    steps_d   = cmd_steps;
                    aborted_d = 1'b0;
                    // a zero-length command goes straight to completion
                    state_d   = (cmd_steps == STEP_ZERO) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d   = m_q ? (cnt_q + CNT_ONE) : (cnt_q - CNT_ONE);
                    steps_d = steps_q - STEP_ONE;
                    if (steps_q == STEP_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; cnt_en follows abort combinationally in RUN.
    always_comb begin
        cmd_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        cnt_en     = step;
        m          = m_q;
        q          = cnt_q;
        steps_left = steps_q;
        aborted    = aborted_q;
    end

endmodule

// File: tb/tb_updown_step_ctrl.sv
// Randomized bench for updown_step_ctrl against a timeline-based model:
// each command is tracked by its accept cycle, length and end cycle.
module tb_updown_step_ctrl;

    localparam int WIDTH  = 2;
    localparam int STEP_W = 4;
    localparam int QMOD   = 1 << WIDTH;
    localparam int NCYC   = 4000;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [STEP_W-1:0] cmd_steps;
    logic              abort;
    logic              m;
    logic              cnt_en;
    logic [WIDTH-1:0]  q;
    logic [STEP_W-1:0] steps_left;
    logic              busy;
    logic              done;
    logic              aborted;

    int checks = 0;
    int errors = 0;

    updown_step_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .abort      (abort),
        .m          (m),
        .cnt_en     (cnt_en),
        .q          (q),
        .steps_left (steps_left),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a command accepted at the edge closing cycle k-1 owns
    // cycles k .. k+end_t; cycle k+end_t is its completion pulse. Cycle k is
    // the settle cycle, cycles k+1..k+n step once each.
    bit known    = 0;
    bit act_m    = 0;
    int k_m      = 0;
    int n_m      = 0;
    int end_t    = 0;
    int dir_m    = 0;
    int q_m      = 0;
    int sl_m     = 0;
    int ab_m     = 0;
    int cyc      = 0;

    initial begin
        reset = 1'b1; cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 4'd3; abort = 1'b0;
        for (int i = 0; i < NCYC; i++) begin
            int t;
            int e_ready, e_busy, e_done, e_en;
            @(negedge clk);
            if (i < 3) begin
                reset = 1'b1; cmd_valid = 1'b1; abort = 1'b0;
            end else begin
                reset     = ($urandom_range(0, 149) == 0);
                cmd_valid = ($urandom_range(0, 1) == 1);
                cmd_dir   = $urandom_range(0, 1);
                cmd_steps = ($urandom_range(0, 3) == 0) ? STEP_W'($urandom_range(0, 15))
                                                         : STEP_W'($urandom_range(0, 4));
                abort     = ($urandom_range(0, 9) == 0);
            end
            #1;
            if (known) begin
                t = cyc - k_m;
                e_ready = 1; e_busy = 0; e_done = 0; e_en = 0;
                if (act_m) begin
                    e_ready = 0; e_busy = 1;
                    if (t == end_t) e_done = 1;
                    else if (t >= 1) e_en = abort ? 0 : 1;
                end
                check_val("cmd_ready", cmd_ready, e_ready);
                check_val("busy", busy, e_busy);
                check_val("done", done, e_done);
                check_val("cnt_en", cnt_en, e_en);
                check_val("q", q, q_m);
                check_val("steps_left", steps_left, sl_m);
                check_val("m", m, dir_m);
                check_val("aborted", aborted, ab_m);
            end
            @(posedge clk);
            if (reset) begin
                known = 1; act_m = 0; q_m = 0; sl_m = 0; dir_m = 0; ab_m = 0;
            end else if (known) begin
                t = cyc - k_m;
                if (!act_m) begin
                    if (cmd_valid) begin
                        act_m = 1; k_m = cyc + 1; n_m = int'(cmd_steps);
                        dir_m = int'(cmd_dir); sl_m = n_m; ab_m = 0;
                        end_t = (n_m == 0) ? 0 : n_m + 1;
                    end
                end else if (t == end_t) begin
                    act_m = 0;
                end else if (abort) begin
                    ab_m = 1; end_t = t + 1;
                end else if (t >= 1) begin
                    q_m  = (q_m + (dir_m != 0 ? 1 : QMOD - 1)) % QMOD;
                    sl_m = sl_m - 1;
                end
            end
            cyc++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
